thermo_decoder_rx: RTL and testbench
====================================

Name: thermo_decoder_rx

Overview:
- Receive-side counterpart of the byte-wide thermometer shift-register path.
- Collects a 256-bit thermometer code arriving 8 bits per accepted beat, then decodes it sequentially, one chunk per cycle, into a binary count.
- Flags codes that are not a valid thermometer pattern ("bubbles") and sits on the input side of the chip, fed from dedicated inputs.

Parameters:
- CHUNK_W, 8, bits per input beat.
- N_CHUNKS, 32, beats per frame; frame width = CHUNK_W*N_CHUNKS = 256.
- CNT_W, $clog2(CHUNK_W*N_CHUNKS+1) = 9, result width, so that 256 is representable.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  CHUNK_W  thermometer chunk; the first beat of a frame is the most significant chunk.
- din_valid  input  1  beat qualifier; a beat is accepted when din_valid && din_ready.
- din_ready  output  1  high while collecting.
- clear  input  1  synchronous abort of the current frame.
- result  output  CNT_W  number of ones in the last decoded frame.
- error  output  1  last decoded frame was not a valid thermometer code.
- result_valid  output  1  one-cycle pulse when result and error update.
- overrun  output  1  sticky: a beat was presented while din_ready was low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=COLLECT, beat counter=0, frame register=0.
  - result=0, error=0, result_valid=0, overrun=0, din_ready=1.
- State COLLECT (din_ready=1):
  - Each accepted beat shifts in at the LSB end: frame <= {frame[255-CHUNK_W:0], din}.
  - The beat counter increments on each accepted beat.
  - On the edge accepting beat N_CHUNKS: counter returns to 0, chunk index k=0, ones accumulator=0, seen_zero=0, error accumulator=0, state goes to DECODE.
- State DECODE (din_ready=0):
  - One chunk per edge, LSB-first: chunk k = frame[k*CHUNK_W +: CHUNK_W], k = 0..N_CHUNKS-1.
  - The ones accumulator adds popcount(chunk).
  - The error accumulator is set if the chunk is not of the form 2^n-1 (n = 0..CHUNK_W).
  - The error accumulator is also set if seen_zero=1 and the chunk is nonzero.
  - seen_zero is set if the chunk != all-ones.
  - On the edge processing k=N_CHUNKS-1, the final values are registered: result <= full popcount, error <= final error flag, result_valid <= 1, state <= COLLECT.
- Latency:
  - Last beat accepted on edge E0; chunk k is processed on edge E(k+1).
  - result_valid is high from E32 to E33; din_ready is high again from E32.
  - A new frame's first beat may be accepted in the cycle result_valid is high.
- result and error hold their values until the next decode completes.
- Popcount is reported even when error=1.
- Extra beats: din_valid high while din_ready=0 drops the beat and sets overrun. overrun stays set until clear or reset.
- clear (synchronous, priority over din_valid in any state):
  - state=COLLECT, beat counter=0, decode aborted, result_valid=0, overrun=0.
  - result and error are retained.
  - The frame register is not cleared; it is fully overwritten by the next 32 beats.
- Reset asserted mid-collect or mid-decode: immediate return to reset values; no result_valid pulse.
- Widths:
  - The accumulator is CNT_W bits and cannot overflow (maximum 256).
  - The beat counter and chunk index are $clog2(N_CHUNKS) bits and wrap only via the explicit transitions above.

Test Plan:
1. Reset check: assert rst_n low with no clock edge -> result=0, error=0, result_valid=0, overrun=0, din_ready=1.
2. Value 100: send 19 beats of 8'h00, then 8'h0F, then 12 beats of 8'hFF.
   - result_valid pulses exactly 32 edges after the last beat is accepted.
   - result=100, error=0.
   - din_ready is low during the 32 decode cycles.
3. Extremes:
   - 32 beats of 8'hFF -> result=256, error=0.
   - 32 beats of 8'h00 -> result=0, error=0.
   - Back-to-back frames with a beat accepted during the result_valid cycle -> both decode correctly.
4. Bubbles:
   - 31 beats of 8'h00, then 8'hFD -> result=7, error=1.
   - Frame with chunk0=8'h0F and chunk3=8'h01 (ones above a zero) -> result=5, error=1.
5. Overrun: din_valid=1 during DECODE -> beat dropped, overrun=1, decoded result unchanged; a subsequent clear sets overrun=0.
6. Aborts:
   - clear after 10 beats -> next 32 beats form a clean frame.
   - rst_n low at decode cycle 15 -> no result_valid pulse, all outputs at reset values, din_ready=1 after release.

Source files
------------

// File: rtl/thermo_decoder_rx.sv
// Receive-side thermometer decoder: collects a 256-bit code 8 bits per beat,
// then walks it one chunk per cycle to produce a ones count and a bubble flag.
module thermo_decoder_rx #(
   parameter int CHUNK_W  = 8,
   parameter int N_CHUNKS = 32,
   parameter int CNT_W    = $clog2(CHUNK_W*N_CHUNKS+1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [CHUNK_W-1:0] din,
   input  logic               din_valid,
   output logic               din_ready,
   input  logic               clear,
   output logic [CNT_W-1:0]   result,
   output logic               error,
   output logic               result_valid,
   output logic               overrun
);

   localparam int FRAME_W = CHUNK_W*N_CHUNKS;
   localparam int IDX_W   = $clog2(N_CHUNKS);

   typedef enum logic {COLLECT = 1'b0, DECODE = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [FRAME_W-1:0] frame;
   logic [IDX_W-1:0]   beat_cnt;
   logic [IDX_W-1:0]   chunk_idx;
   logic [CNT_W-1:0]   ones_acc;
   logic               seen_zero;
   logic               err_acc;

   logic [CHUNK_W-1:0] chunk;
   logic               beat_acc, beat_last, idx_last;
   logic [CNT_W-1:0]   ones_nxt;
   logic               err_nxt;

   function automatic logic [CNT_W-1:0] popcount(input logic [CHUNK_W-1:0] c);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < CHUNK_W; i++) n = n + CNT_W'(c[i]);
      return n;
   endfunction

   // A legal chunk is 2^n-1: adding one must clear every set bit.
   function automatic logic is_thermo(input logic [CHUNK_W-1:0] c);
      return (c & (c + CHUNK_W'(1))) == '0;
   endfunction

   assign din_ready = (state == COLLECT);
   assign beat_acc  = din_valid && (state == COLLECT);
   assign beat_last = (beat_cnt == IDX_W'(N_CHUNKS-1));
   assign idx_last  = (chunk_idx == IDX_W'(N_CHUNKS-1));
   assign chunk     = frame[chunk_idx*CHUNK_W +: CHUNK_W];
   assign ones_nxt  = ones_acc + popcount(chunk);
   assign err_nxt   = err_acc || !is_thermo(chunk) || (seen_zero && (chunk != '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (beat_acc && beat_last) state_nxt = DECODE;
         DECODE:  if (idx_last)              state_nxt = COLLECT;
         default:                            state_nxt = COLLECT;
      endcase
      if (clear) state_nxt = COLLECT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame        <= '0;
         beat_cnt     <= '0;
         chunk_idx    <= '0;
         ones_acc     <= '0;
         seen_zero    <= 1'b0;
         err_acc      <= 1'b0;
         result       <= '0;
         error        <= 1'b0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (clear) begin
         beat_cnt     <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (din_valid && state != COLLECT) overrun <= 1'b1;
         if (state == COLLECT) begin
            if (beat_acc) begin
               frame <= {frame[FRAME_W-CHUNK_W-1:0], din};
               if (beat_last) begin
                  beat_cnt  <= '0;
                  chunk_idx <= '0;
                  ones_acc  <= '0;
                  seen_zero <= 1'b0;
                  err_acc   <= 1'b0;
               end else begin
                  beat_cnt <= beat_cnt + IDX_W'(1);
               end
            end
         end else begin
            // Decode walks LSB chunk first; any nonzero chunk after a gap is a bubble.
            ones_acc  <= ones_nxt;
            err_acc   <= err_nxt;
            seen_zero <= seen_zero || (chunk != '1);
            chunk_idx <= chunk_idx + IDX_W'(1);
            if (idx_last) begin
               result       <= ones_nxt;
               error        <= err_nxt;
               result_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_thermo_decoder_rx.sv
// Scoreboard bench for thermo_decoder_rx: driver queues expected results,
// a negedge monitor checks each result_valid pulse, its timing and payload.
module tb_thermo_decoder_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic       clear = 1'b0;
   logic [8:0] result;
   logic       error;
   logic       result_valid;
   logic       overrun;

   thermo_decoder_rx dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .clear(clear), .result(result), .error(error),
      .result_valid(result_valid), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct { int res; int err; int cyc; } exp_t;
   exp_t exp_q[$];

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   logic [7:0] fr [32];

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Monitor: every pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && result_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result_valid", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", int'(result), e.res);
            chk("error", int'(error), e.err);
            chk("latency_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 32; i++) fr[i] = v;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!din_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!din_ready) chk("din_ready_timeout", 0, 1);
   endtask

   task automatic send_beats(input int count);
      for (int i = 0; i < count; i++) begin
         wait_ready();
         din = fr[i];
         din_valid = 1'b1;
         @(posedge clk); #1;
         din_valid = 1'b0;
      end
   endtask

   task automatic send_frame(input bit push, input int res, input int err);
      exp_t e;
      send_beats(32);
      e.res = res; e.err = err; e.cyc = cyc + 32;
      if (push) exp_q.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic frame_100();
      fill(8'h00);
      fr[19] = 8'h0F;
      for (int i = 20; i < 32; i++) fr[i] = 8'hFF;
   endtask

   initial begin
      bit ok;
      // 1: asynchronous reset before any clock edge
      #1 rst_n = 1'b0;
      #2;
      chk("rst_result", int'(result), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_result_valid", int'(result_valid), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_din_ready", int'(din_ready), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 2: value 100, din_ready low for the whole decode
      frame_100();
      send_frame(1, 100, 0);
      ok = 1;
      for (int k = 0; k < 32; k++) begin
         if (din_ready) ok = 0;
         @(posedge clk); #1;
      end
      chk("ready_low_during_decode", int'(ok), 1);
      chk("ready_high_after_decode", int'(din_ready), 1);
      chk("rv_high_at_E32", int'(result_valid), 1);
      drain();

      // 3: extremes, then back-to-back frames
      fill(8'hFF); send_frame(1, 256, 0);
      drain();
      fill(8'h00); send_frame(1, 0, 0);
      drain();
      fill(8'hFF); send_frame(1, 256, 0);
      frame_100(); send_frame(1, 100, 0);
      drain();

      // 4: bubbles
      fill(8'h00); fr[31] = 8'hFD; send_frame(1, 7, 1);
      drain();
      fill(8'h00); fr[31] = 8'h0F; fr[28] = 8'h01; send_frame(1, 5, 1);
      drain();

      // 5: overrun during decode, then cleared
      frame_100();
      send_frame(1, 100, 0);
      din = 8'hAA; din_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      chk("overrun_set", int'(overrun), 1);
      drain();
      chk("overrun_sticky", int'(overrun), 1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("overrun_cleared", int'(overrun), 0);
      chk("result_retained_after_clear", int'(result), 100);

      // 6a: abort after 10 beats, next 32 beats form a clean frame
      fill(8'hFF);
      send_beats(10);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      fill(8'h00);
      for (int i = 28; i < 32; i++) fr[i] = 8'hFF;
      send_frame(1, 32, 0);
      drain();

      // 6b: reset in the middle of decode
      fill(8'hFF);
      send_frame(0, 0, 0);
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_result", int'(result), 0);
      chk("midrst_error", int'(error), 0);
      chk("midrst_result_valid", int'(result_valid), 0);
      chk("midrst_overrun", int'(overrun), 0);
      chk("midrst_din_ready", int'(din_ready), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("postrst_din_ready", int'(din_ready), 1);
      repeat (40) @(posedge clk);
      #1;
      chk("postrst_result", int'(result), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
